dmem_arbiter: RTL

- Shares the single-port data RAM between the processor and one auxiliary requester, such as a VGA/score reader or an accelerometer logger.
- The processor has absolute priority because it cannot stall.
- The auxiliary requester uses a capture/ack handshake. Its access is issued only in cycles where the CPU is not doing lw/sw, and read data returns with a valid pulse.
- Sits between processor, RAM and the peripheral in the top-level wrapper.

---
 rtl/dmem_arb_pkg.sv | 18 +
 rtl/dmem_arb_sat_counter.sv | 37 +++
 rtl/dmem_arbiter.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared constants for the data-RAM arbiter: FSM encoding, default widths,
// statistics counter width and a width helper for saturating counters.
package dmem_arb_pkg;

  localparam int DEF_ADDR_W = 12;
  localparam int DEF_DATA_W = 32;
  localparam int STAT_W     = 16;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_PEND   = 2'd1;
  localparam logic [1:0] ST_RDWAIT = 2'd2;

  // Bits needed to hold values 0..max_val inclusive.
  function automatic int cnt_w(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/dmem_arb_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module dmem_arb_sat_counter
  import dmem_arb_pkg::*;
#(
  parameter int             W   = 8,
  parameter logic [W-1:0]   MAX = '1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != MAX)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/dmem_arbiter.sv
// Data-RAM arbiter: CPU has absolute priority, one auxiliary requester is
// served in CPU-idle cycles. Optional counters: define DMEM_ARBITER_STATS_EN.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int RD_LATENCY   = 1,
  parameter int STARVE_LIMIT = 64
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_wren,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              per_req,
  input  logic              per_wren,
  input  logic [ADDR_W-1:0] per_addr,
  input  logic [DATA_W-1:0] per_wdata,
  output logic              per_ack,
  output logic              per_rvalid,
  output logic [DATA_W-1:0] per_rdata,
  output logic              per_starve,
  output logic              ram_wen,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
`ifdef DMEM_ARBITER_STATS_EN
  ,
  output logic [STAT_W-1:0] stat_issued,
  output logic [STAT_W-1:0] stat_blocked
`endif
);

  localparam int              SW         = cnt_w(STARVE_LIMIT);
  localparam logic [SW-1:0]   STARVE_MAX = SW'(STARVE_LIMIT);
  localparam logic [2:0]      LAT_INIT   = 3'(RD_LATENCY);

  logic [1:0]        state_q,      state_d;
  logic              hold_wren_q,  hold_wren_d;
  logic [ADDR_W-1:0] hold_addr_q,  hold_addr_d;
  logic [DATA_W-1:0] hold_wdata_q, hold_wdata_d;
  logic [2:0]        lat_q,        lat_d;
  logic              per_ack_q,    per_ack_d;
  logic              per_rvalid_q, per_rvalid_d;
  logic [DATA_W-1:0] per_rdata_q,  per_rdata_d;

  logic              issue;
  logic              blocked;
  logic              per_sel;
  logic [SW-1:0]     starve_cnt;

  assign issue   = (state_q == ST_PEND) && !cpu_req;
  assign blocked = (state_q == ST_PEND) && cpu_req;
  assign per_sel = issue && !reset;

  always_comb begin
    state_d      = state_q;
    hold_wren_d  = hold_wren_q;
    hold_addr_d  = hold_addr_q;
    hold_wdata_d = hold_wdata_q;
    lat_d        = lat_q;
    per_ack_d    = 1'b0;
    per_rvalid_d = 1'b0;
    per_rdata_d  = per_rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (per_req) begin
          hold_wren_d  = per_wren;
          hold_addr_d  = per_addr;
          hold_wdata_d = per_wdata;
          per_ack_d    = 1'b1;
          state_d      = ST_PEND;
        end
      end
      ST_PEND: begin
        if (issue) begin
          if (hold_wren_q) begin
            state_d = ST_IDLE;
          end else begin
            lat_d   = LAT_INIT;
            state_d = ST_RDWAIT;
          end
        end
      end
      ST_RDWAIT: begin
        // lat_q == 1 is the cycle the RAM presents the data for our address
        lat_d = lat_q - 3'd1;
        if (lat_q == 3'd1) begin
          per_rdata_d  = ram_rdata;
          per_rvalid_d = 1'b1;
          state_d      = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      hold_wren_q  <= 1'b0;
      hold_addr_q  <= '0;
      hold_wdata_q <= '0;
      lat_q        <= '0;
      per_ack_q    <= 1'b0;
      per_rvalid_q <= 1'b0;
      per_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      hold_wren_q  <= hold_wren_d;
      hold_addr_q  <= hold_addr_d;
      hold_wdata_q <= hold_wdata_d;
      lat_q        <= lat_d;
      per_ack_q    <= per_ack_d;
      per_rvalid_q <= per_rvalid_d;
      per_rdata_q  <= per_rdata_d;
    end
  end

  // RAM port mux: the peripheral only ever gets cycles the CPU leaves unused
  always_comb begin
    if (per_sel) begin
      ram_addr  = hold_addr_q;
      ram_wdata = hold_wdata_q;
      ram_wen   = hold_wren_q;
    end else begin
      ram_addr  = cpu_addr;
      ram_wdata = cpu_wdata;
      ram_wen   = cpu_req & cpu_wren & ~reset;
    end
  end

  dmem_arb_sat_counter #(
    .W   (SW),
    .MAX (STARVE_MAX)
  ) u_starve_cnt (
    .clk (clock),
    .rst (reset),
    .inc (blocked),
    .clr (issue),
    .cnt (starve_cnt)
  );

`ifdef DMEM_ARBITER_STATS_EN
  dmem_arb_sat_counter #(
    .W (STAT_W)
  ) u_stat_issued (
    .clk (clock),
    .rst (reset),
    .inc (issue),
    .clr (1'b0),
    .cnt (stat_issued)
  );

  dmem_arb_sat_counter #(
    .W (STAT_W)
  ) u_stat_blocked (
    .clk (clock),
    .rst (reset),
    .inc (blocked),
    .clr (1'b0),
    .cnt (stat_blocked)
  );
`endif

  assign cpu_rdata  = ram_rdata;
  assign per_ack    = per_ack_q;
  assign per_rvalid = per_rvalid_q;
  assign per_rdata  = per_rdata_q;
  assign per_starve = (starve_cnt >= STARVE_MAX);

endmodule
